// File: rtl/module4_fine_cfo_cmul_seq.sv
// module4_fine_cfo_cmul_seq: sequential complex rotator sharing one signed multiplier across four partial products
module module4_fine_cfo_cmul_seq #(
  parameter int W         = 16,
  parameter int FRAC_BITS = 15,
  parameter int CNT_W     = 16
) (
  input  logic             ap_clk,
  input  logic             ap_rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_i,
  input  logic [W-1:0]     in_q,
  input  logic [W-1:0]     in_cos,
  input  logic [W-1:0]     in_sin,
  input  logic             in_bypass,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_i,
  output logic [W-1:0]     out_q,
  input  logic             stat_clr,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] sat_cnt
);
  localparam int PW = 2 * W;
  localparam int AW = 2 * W + 1;
  localparam logic signed [AW-1:0] RND  = AW'(1) << (FRAC_BITS - 1);
  localparam logic signed [AW-1:0] MAXV = AW'((2 ** (W - 1)) - 1);
  localparam logic signed [AW-1:0] MINV = ~MAXV;
  typedef enum logic [2:0] {IDLE, M0, M1, M2, M3, OUT} state_t;
  state_t                 state_q, state_d;
  logic signed [W-1:0]    smp_i_q, smp_i_d, smp_q_q, smp_q_d, cos_q, cos_d, sin_q, sin_d;
  logic                   byp_q, byp_d;
  logic signed [AW-1:0]   acc_re_q, acc_re_d, acc_im_q, acc_im_d;
  logic [W-1:0]           out_i_q, out_i_d, out_q_q, out_q_d;
  logic [CNT_W-1:0]       sample_cnt_q, sample_cnt_d, sat_cnt_q, sat_cnt_d;
  logic signed [W-1:0]    mul_a, mul_b;
  logic signed [PW-1:0]   prod;
  logic signed [AW-1:0]   im_fin, re_rnd, im_rnd;
  logic [W-1:0]           re_clip, im_clip;
  logic                   re_sat, im_sat, accept, out_hs, m3;
  logic [1:0]             sat_inc;
  logic [CNT_W:0]         sat_sum;
  // operand mux: one partial product per M state, multiplier idle otherwise
  always_comb begin
    mul_a  = (state_q == M0 || state_q == M2) ? smp_i_q : (state_q == M1 || state_q == M3) ? smp_q_q : '0;
    mul_b  = (state_q == M0 || state_q == M3) ? cos_q : (state_q == M1 || state_q == M2) ? sin_q : '0;
    prod   = PW'(mul_a) * PW'(mul_b);
    im_fin = acc_im_q + AW'(prod);
    re_rnd = (acc_re_q + RND) >>> FRAC_BITS;
    im_rnd = (im_fin + RND) >>> FRAC_BITS;
    re_sat = (re_rnd > MAXV) || (re_rnd < MINV);
    im_sat = (im_rnd > MAXV) || (im_rnd < MINV);
    re_clip = (re_rnd > MAXV) ? MAXV[W-1:0] : (re_rnd < MINV) ? MINV[W-1:0] : re_rnd[W-1:0];
    im_clip = (im_rnd > MAXV) ? MAXV[W-1:0] : (im_rnd < MINV) ? MINV[W-1:0] : im_rnd[W-1:0];
  end
  // handshake decode and next-state sequencing
  always_comb begin
    in_ready  = (state_q == IDLE) || (state_q == OUT && out_ready);
    out_valid = (state_q == OUT);
    accept    = in_valid && in_ready;
    out_hs    = (state_q == OUT) && out_ready;
    m3        = (state_q == M3);
    state_d   = state_q;
    case (state_q)
      IDLE:    state_d = accept ? M0 : IDLE;
      M0:      state_d = M1;
      M1:      state_d = M2;
      M2:      state_d = M3;
      M3:      state_d = OUT;
      OUT:     state_d = out_ready ? (in_valid ? M0 : IDLE) : OUT;
      default: state_d = IDLE;
    endcase
  end
  // capture, accumulate, output load and saturating statistics
  always_comb begin
    smp_i_d  = accept ? in_i : smp_i_q;
    smp_q_d  = accept ? in_q : smp_q_q;
    cos_d    = accept ? in_cos : cos_q;
    sin_d    = accept ? in_sin : sin_q;
    byp_d    = accept ? in_bypass : byp_q;
    acc_re_d = accept ? '0 : (state_q == M0) ? AW'(prod) : (state_q == M1) ? acc_re_q - AW'(prod) : acc_re_q;
    acc_im_d = accept ? '0 : (state_q == M2) ? AW'(prod) : m3 ? im_fin : acc_im_q;
    out_i_d  = !m3 ? out_i_q : byp_q ? smp_i_q : re_clip;
    out_q_d  = !m3 ? out_q_q : byp_q ? smp_q_q : im_clip;
    sat_inc  = (m3 && !byp_q) ? {1'b0, re_sat} + {1'b0, im_sat} : 2'd0;
    sat_sum  = {1'b0, sat_cnt_q} + (CNT_W + 1)'(sat_inc);
    sat_cnt_d = stat_clr ? '0 : sat_sum[CNT_W] ? '1 : sat_sum[CNT_W-1:0];
    sample_cnt_d = stat_clr ? '0 : (out_hs && !(&sample_cnt_q)) ? sample_cnt_q + CNT_W'(1) : sample_cnt_q;
  end
  // state and datapath registers, cleared asynchronously
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q      <= IDLE;
      smp_i_q      <= '0;
      smp_q_q      <= '0;
      cos_q        <= '0;
      sin_q        <= '0;
      byp_q        <= 1'b0;
      acc_re_q     <= '0;
      acc_im_q     <= '0;
      out_i_q      <= '0;
      out_q_q      <= '0;
      sample_cnt_q <= '0;
      sat_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      smp_i_q      <= smp_i_d;
      smp_q_q      <= smp_q_d;
      cos_q        <= cos_d;
      sin_q        <= sin_d;
      byp_q        <= byp_d;
      acc_re_q     <= acc_re_d;
      acc_im_q     <= acc_im_d;
      out_i_q      <= out_i_d;
      out_q_q      <= out_q_d;
      sample_cnt_q <= sample_cnt_d;
      sat_cnt_q    <= sat_cnt_d;
    end
  end
  assign out_i      = out_i_q;
  assign out_q      = out_q_q;
  assign sample_cnt = sample_cnt_q;
  assign sat_cnt    = sat_cnt_q;
endmodule
